// File: rtl/fft32_in_buf.sv
// Ping-pong 32-point input frame buffer and stage sequencer for the FFT.
// Optional FFT_BITREV_EN: store beats at bit-reversed slots.
module fft32_in_buf #(
  parameter int NB   = 9,
  parameter int GAP  = 4,
  parameter int LEAD = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DIN_VLD,
  output logic            DIN_RDY,
  input  logic [NB*4-1:0] DIN_RE,
  input  logic [NB*4-1:0] DIN_IM,
  input  logic            STAGE_SEL,
  output logic            START,
  output logic            STAGE,
  output logic            DOUT_VLD,
  output logic            DOUT_LAST,
  output logic [NB*4-1:0] DOUT_RE,
  output logic [NB*4-1:0] DOUT_IM,
  output logic            BUSY
);

  localparam int W = NB * 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_EMIT
  } st_t;

  st_t st, st_n;

  logic [1:0] full;
  logic [1:0] tag;
  logic [1:0] fset;
  logic [1:0] fclr;
  logic       wb;
  logic       rb;
  logic       gb;
  logic [2:0] wc;
  logic [2:0] wslot;
  logic [2:0] rc;
  logic [2:0] lc;
  logic [3:0] ph;
  logic       acc;
  logic       wdone;
  logic       go;
  logic       emit;
  logic       fin;
  logic       ph_end;

  logic [W-1:0] mem_re [16];
  logic [W-1:0] mem_im [16];

  assign acc    = DIN_VLD && DIN_RDY;
  assign wdone  = acc && (wc == 3'd7);
  assign ph_end = (ph == 4'(GAP - 1));

`ifdef FFT_BITREV_EN
  assign wslot = {wc[0], wc[1], wc[2]};
`else
  assign wslot = wc;
`endif

  always_ff @(posedge CLK) begin
    if (acc) begin
      mem_re[{wb, wslot}] <= DIN_RE;
      mem_im[{wb, wslot}] <= DIN_IM;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb  <= 1'b0;
      wc  <= 3'd0;
      tag <= 2'b00;
    end else if (acc) begin
      wc <= wc + 3'd1;
      if (wc == 3'd0)
        tag[wb] <= STAGE_SEL;
      if (wdone)
        wb <= ~wb;
    end
  end

  // a set and a clear never hit the same bank: writer skips full banks
  assign fset = {wdone && wb, wdone && !wb};
  assign fclr = {fin && rb, fin && !rb};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      full <= 2'b00;
    else
      full <= (full & ~fclr) | fset;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      st <= S_IDLE;
    else
      st <= st_n;
  end

  always_comb begin
    st_n = st;
    go   = 1'b0;
    emit = 1'b0;
    fin  = 1'b0;
    unique case (1'b1)
      st == S_IDLE: begin
        if (full[rb]) begin
          go   = 1'b1;
          st_n = S_LEAD;
        end
      end
      st == S_LEAD: begin
        if (lc == 3'(LEAD - 1))
          st_n = S_EMIT;
      end
      st == S_EMIT: begin
        emit = (ph == 4'd0);
        if (ph_end && rc == 3'd7) begin
          fin = 1'b1;
          if (full[~rb]) begin
            go   = 1'b1;
            st_n = S_LEAD;
          end else begin
            st_n = S_IDLE;
          end
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lc <= 3'd0;
      ph <= 4'd0;
      rc <= 3'd0;
      rb <= 1'b0;
    end else begin
      if (go)
        lc <= 3'd0;
      else if (st == S_LEAD)
        lc <= lc + 3'd1;
      if (st == S_LEAD) begin
        ph <= 4'd0;
        rc <= 3'd0;
      end else if (st == S_EMIT) begin
        ph <= ph_end ? 4'd0 : ph + 4'd1;
        if (ph_end)
          rc <= rc + 3'd1;
      end
      if (fin)
        rb <= ~rb;
    end
  end

  // bank whose frame START announces
  assign gb = (st == S_EMIT) ? ~rb : rb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      START     <= 1'b0;
      STAGE     <= 1'b0;
      DOUT_VLD  <= 1'b0;
      DOUT_LAST <= 1'b0;
      DOUT_RE   <= '0;
      DOUT_IM   <= '0;
    end else begin
      START     <= go;
      DOUT_VLD  <= emit;
      DOUT_LAST <= emit && (rc == 3'd7);
      if (go)
        STAGE <= tag[gb];
      if (emit) begin
        DOUT_RE <= mem_re[{rb, rc}];
        DOUT_IM <= mem_im[{rb, rc}];
      end
    end
  end

  always_comb begin
    DIN_RDY = ~full[wb];
    BUSY    = (st != S_IDLE);
  end

endmodule

// File: tb/tb_fft32_in_buf.sv
// Scoreboard bench for fft32_in_buf.
// Monitor pops expected beats on each DOUT_VLD strobe.
module tb_fft32_in_buf;

  localparam int NB   = 9;
  localparam int GAP  = 4;
  localparam int LEAD = 2;
  localparam int W    = NB * 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         DIN_VLD = 1'b0;
  logic         STAGE_SEL = 1'b0;
  logic [W-1:0] DIN_RE = '0;
  logic [W-1:0] DIN_IM = '0;
  logic         DIN_RDY;
  logic         START;
  logic         STAGE;
  logic         DOUT_VLD;
  logic         DOUT_LAST;
  logic [W-1:0] DOUT_RE;
  logic [W-1:0] DOUT_IM;
  logic         BUSY;

  fft32_in_buf #(.NB(NB), .GAP(GAP), .LEAD(LEAD)) dut (
    .CLK(CLK),
    .RST(RST),
    .DIN_VLD(DIN_VLD),
    .DIN_RDY(DIN_RDY),
    .DIN_RE(DIN_RE),
    .DIN_IM(DIN_IM),
    .STAGE_SEL(STAGE_SEL),
    .START(START),
    .STAGE(STAGE),
    .DOUT_VLD(DOUT_VLD),
    .DOUT_LAST(DOUT_LAST),
    .DOUT_RE(DOUT_RE),
    .DOUT_IM(DOUT_IM),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
    logic         stg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   start_t[$];
  int   strobe_t[$];
  int   n_start = 0;
  int   n_strobe = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic logic [W-1:0] mk_re(input int base, input int beat);
    logic [W-1:0] v;
    for (int l = 0; l < 4; l++)
      v[NB*l +: NB] = NB'(base + beat * 4 + l);
    return v;
  endfunction

  function automatic logic [W-1:0] mk_im(input int base, input int beat);
    logic [W-1:0] v;
    for (int l = 0; l < 4; l++)
      v[NB*l +: NB] = NB'(511 - (base + beat * 4 + l));
    return v;
  endfunction

  // input beat index carried by the k-th output strobe of a frame
  function automatic int ord(input int k);
`ifdef FFT_BITREV_EN
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
    return k;
`endif
  endfunction

  task automatic push_frame(input int base, input logic stg);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.re   = mk_re(base, ord(k));
      e.im   = mk_im(base, ord(k));
      e.last = (k == 7);
      e.stg  = stg;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (START) begin
        n_start++;
        start_t.push_back(cyc);
      end
      if (DOUT_LAST && !DOUT_VLD)
        chk("last_without_vld", 1, 0);
      if (DOUT_VLD) begin
        n_strobe++;
        strobe_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("extra_strobe", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_re", DOUT_RE, mon_e.re);
          chk("beat_im", DOUT_IM, mon_e.im);
          chk("beat_last", DOUT_LAST, mon_e.last);
          chk("beat_stage", STAGE, mon_e.stg);
        end
      end
    end
  end

  // drive one beat; STAGE_SEL is inverted on non-first beats
  task automatic send_beat(input int base, input int beat, input logic stg,
                           output int stalls, output int acc_cyc);
    DIN_VLD   = 1'b1;
    DIN_RE    = mk_re(base, beat);
    DIN_IM    = mk_im(base, beat);
    STAGE_SEL = (beat == 0) ? stg : ~stg;
    stalls    = 0;
    while (!DIN_RDY && stalls < 200) begin
      @(posedge CLK);
      #1;
      stalls++;
    end
    if (!DIN_RDY)
      chk("rdy_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge CLK);
    #1;
    DIN_VLD = 1'b0;
    if (beat == 7)
      push_frame(base, stg);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (n_strobe < n && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("strobe_count", n_strobe, n);
  endtask

  task automatic clear_trace();
    start_t.delete();
    strobe_t.delete();
    n_start  = 0;
    n_strobe = 0;
  endtask

  int st;
  int ac;
  int t0;
  int rdy_cyc;
  int early;
  int seen;
  int pre_s;
  int pre_n;
  int g;
  int bases[3] = '{40, 80, 120};
  logic tags[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_start", START, 0);
    chk("rst_stage", STAGE, 0);
    chk("rst_vld", DOUT_VLD, 0);
    chk("rst_last", DOUT_LAST, 0);
    chk("rst_re", DOUT_RE, 0);
    chk("rst_im", DOUT_IM, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rdy", DIN_RDY, 1);
    RST = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    chk("idle_no_start", n_start, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_rdy", DIN_RDY, 1);

    // single frame, stage 1
    clear_trace();
    for (int b = 0; b < 8; b++)
      send_beat(0, b, 1'b1, st, ac);
    wait_strobes(8, 200);
    chk("single_starts", n_start, 1);
    if (start_t.size() == 1 && strobe_t.size() == 8) begin
      chk("single_first_lat", strobe_t[0] - start_t[0], LEAD + 1);
      for (int i = 1; i < 8; i++)
        chk("single_gap", strobe_t[i] - strobe_t[i-1], GAP);
    end else begin
      chk("single_trace", 0, 1);
    end
    repeat (10) @(posedge CLK);
    #1;

    // back-pressure, tags 0,1,0
    clear_trace();
    early   = 0;
    rdy_cyc = 0;
    for (int i = 0; i < 24; i++) begin
      send_beat(bases[i/8], i % 8, tags[i/8], st, ac);
      if (i < 16 && st != 0)
        early++;
      if (i == 16) begin
        chk("bp_stall_at_16", st > 0, 1);
        rdy_cyc = ac;
      end
    end
    chk("bp_no_early_stall", early, 0);
    wait_strobes(24, 400);
    chk("bp_starts", n_start, 3);
    if (start_t.size() == 3 && strobe_t.size() == 24) begin
      chk("bp_rdy_return", rdy_cyc - strobe_t[7], GAP - 1);
      chk("bp_b2b_start", start_t[1] - strobe_t[7], GAP - 1);
      chk("bp_start_gap1", start_t[1] - start_t[0], LEAD + 8 * GAP);
      chk("bp_start_gap2", start_t[2] - start_t[1], LEAD + 8 * GAP);
      chk("bp_lat_f1", strobe_t[8] - start_t[1], LEAD + 1);
    end else begin
      chk("bp_trace", 0, 1);
    end
    repeat (10) @(posedge CLK);
    #1;

    // frame 1 completes as frame 0's last beat period ends
    clear_trace();
    for (int b = 0; b < 8; b++)
      send_beat(200, b, 1'b1, st, ac);
    g = 0;
    while (start_t.size() == 0 && g < 100) begin
      @(posedge CLK);
      #1;
      g++;
    end
    chk("sim_start_seen", start_t.size(), 1);
    t0 = (start_t.size() > 0) ? start_t[0] : cyc;
    g  = 0;
    while (cyc < t0 + 26 && g < 100) begin
      @(posedge CLK);
      #1;
      g++;
    end
    for (int b = 0; b < 8; b++)
      send_beat(250, b, 1'b0, st, ac);
    chk("sim_beat7_cycle", ac, t0 + 8 * GAP + 1);
    wait_strobes(16, 300);
    chk("sim_starts", n_start, 2);
    if (start_t.size() == 2)
      chk("sim_start_gap", start_t[1] - start_t[0], LEAD + 1 + 8 * GAP);
    else
      chk("sim_trace", 0, 1);
    repeat (10) @(posedge CLK);
    #1;

    // reset during beat 3 with the other bank full
    clear_trace();
    for (int b = 0; b < 8; b++)
      send_beat(300, b, 1'b1, st, ac);
    for (int b = 0; b < 8; b++)
      send_beat(340, b, 1'b1, st, ac);
    seen = (n_strobe > 0) ? n_strobe : 0;
    g    = 0;
    while (seen < 4 && g < 200) begin
      @(posedge CLK);
      #1;
      if (DOUT_VLD)
        seen++;
      g++;
    end
    chk("mrst_reached_b3", seen, 4);
    #1;
    RST = 1'b1;
    exp_q.delete();
    #1;
    chk("mrst_vld", DOUT_VLD, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_rdy", DIN_RDY, 1);
    chk("mrst_re", DOUT_RE, 0);
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    pre_s = n_strobe;
    pre_n = n_start;
    repeat (60) @(posedge CLK);
    #1;
    chk("mrst_no_strobe", n_strobe, pre_s);
    chk("mrst_no_start", n_start, pre_n);
    for (int b = 0; b < 8; b++)
      send_beat(400, b, 1'b0, st, ac);
    wait_strobes(pre_s + 8, 200);
    chk("mrst_new_start", n_start, pre_n + 1);
    repeat (10) @(posedge CLK);
    #1;
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
